regfile_wb_sched: RTL and testbench

//  Write-back scheduler in front of the integer register file's two write ports.

---
 rtl/regfile_wb_sched.sv | 171 +++++++++++++++++
 tb/tb_regfile_wb_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: three per-requester FIFOs drain into the two regfile
// write ports through a rotating-priority arbiter; exports a pending-write bitmap.
module regfile_wb_sched #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [2:0]       req_valid,
  output logic [2:0]       req_ready,
  input  logic [3*AW-1:0]  req_addr,
  input  logic [3*DW-1:0]  req_data,
  output logic             wen0,
  output logic [AW-1:0]    waddr0,
  output logic [DW-1:0]    wdata0,
  output logic             wen1,
  output logic [AW-1:0]    waddr1,
  output logic [DW-1:0]    wdata1,
  output logic [2**AW-1:0] busy,
  output logic             idle
);
  localparam int unsigned NREQ = 3;
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  wb_entry_t       mem   [NREQ][DEPTH];
  logic [PW-1:0]   rptr  [NREQ];
  logic [PW-1:0]   wptr  [NREQ];
  logic [CW-1:0]   count [NREQ];
  logic [1:0]      rr_ptr;

  wb_entry_t       head  [NREQ];
  logic [NREQ-1:0] head_vld;
  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic            g0_vld;
  logic            g1_vld;
  logic [1:0]      g0_idx;
  logic [1:0]      g1_idx;
  logic [1:0]      last_idx;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    return (v >= 3'd3) ? 2'(v - 3'd3) : 2'(v);
  endfunction

  // Accept side; writes to r0 are acknowledged but never stored
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = !flush && (count[i] < CW'(DEPTH));
      push[i]      = req_valid[i] && req_ready[i] && (req_addr[i*AW +: AW] != '0);
      head[i]      = mem[i][rptr[i]];
      head_vld[i]  = (count[i] != '0);
    end
  end

  // Rotating scan; a same-address second head leaves port 1 idle to keep order
  always_comb begin
    logic [1:0] idx;
    logic       done;
    g0_vld = 1'b0;
    g0_idx = '0;
    g1_vld = 1'b0;
    g1_idx = '0;
    idx    = '0;
    done   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = wrap3(3'(rr_ptr) + 3'(k));
      if (head_vld[idx] && !done) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_idx = idx;
        end else begin
          done = 1'b1;
          if (head[idx].addr != head[g0_idx].addr) begin
            g1_vld = 1'b1;
            g1_idx = idx;
          end
        end
      end
    end
    last_idx = g1_vld ? g1_idx : g0_idx;
  end

  always_comb begin
    pop = '0;
    if (!flush) begin
      if (g0_vld) pop[g0_idx] = 1'b1;
      if (g1_vld) pop[g1_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (push[i]) begin
        mem[i][wptr[i]] <= wb_entry_t'{addr: req_addr[i*AW +: AW], data: req_data[i*DW +: DW]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        rptr[i]  <= '0;
        wptr[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NREQ; i++) begin
        rptr[i]  <= '0;
        wptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // Staged write ports and rotation pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      wen0   <= 1'b0;
      waddr0 <= '0;
      wdata0 <= '0;
      wen1   <= 1'b0;
      waddr1 <= '0;
      wdata1 <= '0;
    end else begin
      wen0 <= g0_vld && !flush;
      wen1 <= g1_vld && !flush;
      if (g0_vld && !flush) begin
        waddr0 <= head[g0_idx].addr;
        wdata0 <= head[g0_idx].data;
        rr_ptr <= wrap3(3'(last_idx) + 3'd1);
      end
      if (g1_vld && !flush) begin
        waddr1 <= head[g1_idx].addr;
        wdata1 <= head[g1_idx].data;
      end
    end
  end

  // Pending-write bitmap over occupied FIFO slots and staged ports
  always_comb begin
    logic [PW-1:0] off;
    busy = '0;
    off  = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int s = 0; s < DEPTH; s++) begin
        off = PW'(s) - rptr[i];
        if (CW'(off) < count[i]) busy[mem[i][s].addr] = 1'b1;
      end
    end
    if (wen0) busy[waddr0] = 1'b1;
    if (wen1) busy[waddr1] = 1'b1;
  end

  assign idle = (head_vld == '0) && !wen0 && !wen1;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed scenarios plus a randomized run checked
// against a queue-based model of the scheduling rules.
module tb_regfile_wb_sched;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic [2:0]      req_valid;
  logic [2:0]      req_ready;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic            wen0;
  logic [AW-1:0]   waddr0;
  logic [DW-1:0]   wdata0;
  logic            wen1;
  logic [AW-1:0]   waddr1;
  logic [DW-1:0]   wdata1;
  logic [31:0]     busy;
  logic            idle;

  int n_checks = 0;
  int n_pass   = 0;

  ent_t mq [3][$];

  regfile_wb_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .busy(busy), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]       = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    clear_reqs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (wen0 !== 1'b0) $display("FAIL reset.wen0 got %b exp 0", wen0); else n_pass++;
    n_checks++; if (wen1 !== 1'b0) $display("FAIL reset.wen1 got %b exp 0", wen1); else n_pass++;
    n_checks++; if (waddr0 !== 5'd0 || wdata0 !== 32'd0) $display("FAIL reset.port0 got %h/%h exp 0/0", waddr0, wdata0); else n_pass++;
    n_checks++; if (waddr1 !== 5'd0 || wdata1 !== 32'd0) $display("FAIL reset.port1 got %h/%h exp 0/0", waddr1, wdata1); else n_pass++;
    n_checks++; if (busy !== 32'd0) $display("FAIL reset.busy got %h exp 0", busy); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL reset.idle got %b exp 1", idle); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b111) $display("FAIL reset.ready got %b exp 111", req_ready); else n_pass++;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    n_checks++; if (req_ready[0] !== 1'b1) $display("FAIL single.ready got %b exp 1", req_ready[0]); else n_pass++;
    tick();
    clear_reqs();
    n_checks++; if (wen0 !== 1'b0) $display("FAIL single.n1_wen0 got %b exp 0", wen0); else n_pass++;
    n_checks++; if (busy !== 32'h0000_0020) $display("FAIL single.n1_busy got %h exp 00000020", busy); else n_pass++;
    n_checks++; if (idle !== 1'b0) $display("FAIL single.n1_idle got %b exp 0", idle); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd5) $display("FAIL single.n2_port0 got %b/%0d exp 1/5", wen0, waddr0); else n_pass++;
    n_checks++; if (wdata0 !== 32'hDEAD_BEEF) $display("FAIL single.n2_wdata0 got %h exp deadbeef", wdata0); else n_pass++;
    n_checks++; if (wen1 !== 1'b0) $display("FAIL single.n2_wen1 got %b exp 0", wen1); else n_pass++;
    n_checks++; if (busy !== 32'h0000_0020) $display("FAIL single.n2_busy got %h exp 00000020", busy); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b0 || busy !== 32'd0 || idle !== 1'b1) $display("FAIL single.n3_drained got wen0=%b busy=%h idle=%b exp 0/0/1", wen0, busy, idle); else n_pass++;
  endtask

  task automatic test_rotation();
    do_reset();
    set_req(0, 1'b1, 5'd1, 32'h1111_0001);
    set_req(1, 1'b1, 5'd2, 32'h1111_0002);
    set_req(2, 1'b1, 5'd3, 32'h1111_0003);
    tick();
    clear_reqs();
    n_checks++; if (busy !== 32'h0000_000E) $display("FAIL rot.n1_busy got %h exp 0000000e", busy); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd1 || wdata0 !== 32'h1111_0001) $display("FAIL rot.g1_port0 got %b/%0d/%h exp 1/1/11110001", wen0, waddr0, wdata0); else n_pass++;
    n_checks++; if (wen1 !== 1'b1 || waddr1 !== 5'd2 || wdata1 !== 32'h1111_0002) $display("FAIL rot.g1_port1 got %b/%0d/%h exp 1/2/11110002", wen1, waddr1, wdata1); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd3 || wen1 !== 1'b0) $display("FAIL rot.g2 got wen0=%b waddr0=%0d wen1=%b exp 1/3/0", wen0, waddr0, wen1); else n_pass++;
    // pointer back at 0: req0 must beat req2 for port 0
    set_req(0, 1'b1, 5'd5, 32'h5555_0000);
    set_req(2, 1'b1, 5'd4, 32'h4444_0000);
    tick();
    clear_reqs();
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd5 || wen1 !== 1'b1 || waddr1 !== 5'd4) $display("FAIL rot.ptr0 got %b/%0d %b/%0d exp 1/5 1/4", wen0, waddr0, wen1, waddr1); else n_pass++;
    tick();
  endtask

  task automatic test_conflict();
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h0000_0009);
    tick();
    clear_reqs();
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd9) $display("FAIL conf.setup got %b/%0d exp 1/9", wen0, waddr0); else n_pass++;
    set_req(1, 1'b1, 5'd7, 32'h0000_0011);
    set_req(2, 1'b1, 5'd7, 32'h0000_0022);
    tick();
    clear_reqs();
    n_checks++; if (busy !== 32'h0000_0080 || wen0 !== 1'b0) $display("FAIL conf.queued got busy=%h wen0=%b exp 00000080/0", busy, wen0); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd7 || wdata0 !== 32'h11) $display("FAIL conf.first got %b/%0d/%h exp 1/7/11", wen0, waddr0, wdata0); else n_pass++;
    n_checks++; if (wen1 !== 1'b0) $display("FAIL conf.first_wen1 got %b exp 0", wen1); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd7 || wdata0 !== 32'h22 || wen1 !== 1'b0) $display("FAIL conf.second got %b/%0d/%h wen1=%b exp 1/7/22 0", wen0, waddr0, wdata0, wen1); else n_pass++;
    tick();
    n_checks++; if (idle !== 1'b1) $display("FAIL conf.idle got %b exp 1", idle); else n_pass++;
  endtask

  task automatic test_backpressure();
    int ka, kb, kc, nb, nc;
    logic [2:0] rdy;
    ent_t qa[$];
    ent_t e;
    ka = 0; kb = 0; kc = 0; nb = 0; nc = 0;
    do_reset();
    set_req(0, 1'b1, 5'd9, 32'h0000_0009);
    tick();
    clear_reqs();
    tick();
    tick();
    for (int c = 0; c < 40; c++) begin
      for (int p = 0; p < 2; p++) begin
        if ((p == 0) ? wen0 : wen1) begin
          e.a = (p == 0) ? waddr0 : waddr1;
          e.d = (p == 0) ? wdata0 : wdata1;
          if (e.a >= 5'd10 && e.a <= 5'd13) qa.push_back(e);
          else if (e.a >= 5'd20 && e.a <= 5'd22) nb++;
          else if (e.a >= 5'd24 && e.a <= 5'd26) nc++;
        end
      end
      set_req(0, ka < 4, 5'(10 + ka), 32'hA000_0000 + 32'(ka));
      set_req(1, kb < 3, 5'(20 + kb), 32'hB000_0000 + 32'(kb));
      set_req(2, kc < 3, 5'(24 + kc), 32'hC000_0000 + 32'(kc));
      #1;
      if (c < 2) begin
        n_checks++; if (req_ready[0] !== 1'b1) $display("FAIL bp.ready_c%0d got %b exp 1", c, req_ready[0]); else n_pass++;
      end
      if (c == 2) begin
        n_checks++; if (req_ready[0] !== 1'b0) $display("FAIL bp.ready_full got %b exp 0", req_ready[0]); else n_pass++;
      end
      rdy = req_ready;
      tick();
      if (rdy[0] && ka < 4) ka++;
      if (rdy[1] && kb < 3) kb++;
      if (rdy[2] && kc < 3) kc++;
    end
    clear_reqs();
    n_checks++; if (ka != 4 || kb != 3 || kc != 3) $display("FAIL bp.accepts got %0d/%0d/%0d exp 4/3/3", ka, kb, kc); else n_pass++;
    n_checks++; if (qa.size() != 4) $display("FAIL bp.req0_count got %0d exp 4", qa.size()); else n_pass++;
    for (int j = 0; j < qa.size() && j < 4; j++) begin
      n_checks++;
      if (qa[j].a !== 5'(10 + j) || qa[j].d !== 32'hA000_0000 + 32'(j))
        $display("FAIL bp.order%0d got %0d/%h exp %0d/%h", j, qa[j].a, qa[j].d, 10 + j, 32'hA000_0000 + 32'(j));
      else n_pass++;
    end
    n_checks++; if (nb != 3 || nc != 3) $display("FAIL bp.others got %0d/%0d exp 3/3", nb, nc); else n_pass++;
  endtask

  task automatic test_flush_r0();
    do_reset();
    set_req(0, 1'b1, 5'd0, 32'hBAD0_0000);
    #1;
    n_checks++; if (req_ready[0] !== 1'b1) $display("FAIL flush.r0_ready got %b exp 1", req_ready[0]); else n_pass++;
    tick();
    clear_reqs();
    n_checks++; if (busy !== 32'd0 || idle !== 1'b1) $display("FAIL flush.r0_dropped got busy=%h idle=%b exp 0/1", busy, idle); else n_pass++;
    tick();
    n_checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0) $display("FAIL flush.r0_nowrite got %b%b exp 00", wen0, wen1); else n_pass++;
    set_req(1, 1'b1, 5'd12, 32'h0000_000C);
    set_req(2, 1'b1, 5'd13, 32'h0000_000D);
    tick();
    clear_reqs();
    n_checks++; if (busy !== 32'h0000_3000 || idle !== 1'b0) $display("FAIL flush.queued got busy=%h idle=%b exp 00003000/0", busy, idle); else n_pass++;
    flush = 1'b1;
    set_req(0, 1'b1, 5'd14, 32'h0000_000E);
    #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL flush.ready got %b exp 000", req_ready); else n_pass++;
    tick();
    flush = 1'b0;
    clear_reqs();
    n_checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0 || busy !== 32'd0 || idle !== 1'b1) $display("FAIL flush.after got wen=%b%b busy=%h idle=%b exp 00/0/1", wen0, wen1, busy, idle); else n_pass++;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if ({wen0, wen1} !== 2'b00 || busy !== 32'd0) $display("FAIL flush.quiet%0d got wen=%b%b busy=%h exp 00/0", c, wen0, wen1, busy); else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    set_req(0, 1'b1, 5'd4, 32'h0000_0004);
    set_req(1, 1'b1, 5'd6, 32'h0000_0006);
    set_req(2, 1'b1, 5'd8, 32'h0000_0008);
    tick();
    clear_reqs();
    tick();
    n_checks++; if (wen0 !== 1'b1 || wen1 !== 1'b1) $display("FAIL rstm.pre got %b%b exp 11", wen0, wen1); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (wen0 !== 1'b0 || wen1 !== 1'b0) $display("FAIL rstm.wen got %b%b exp 00", wen0, wen1); else n_pass++;
    n_checks++; if (busy !== 32'd0 || idle !== 1'b1) $display("FAIL rstm.state got busy=%h idle=%b exp 0/1", busy, idle); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++; if ({wen0, wen1} !== 2'b00 || busy !== 32'd0) $display("FAIL rstm.quiet%0d got wen=%b%b busy=%h exp 00/0", c, wen0, wen1, busy); else n_pass++;
    end
  endtask

  task automatic test_random();
    int order[$];
    int rr, last, r;
    logic [2:0] exp_rdy;
    logic [31:0] exp_busy;
    logic mw0, mw1, nw0, nw1, fl;
    logic [AW-1:0] ma0, ma1;
    logic [DW-1:0] md0, md1;
    ent_t e, h;
    do_reset();
    for (int i = 0; i < 3; i++) mq[i].delete();
    mw0 = 1'b0; mw1 = 1'b0; rr = 0;
    ma0 = '0; ma1 = '0; md0 = '0; md1 = '0;
    for (int c = 0; c < 400; c++) begin
      fl = ($urandom_range(0, 19) == 0);
      flush = fl;
      for (int i = 0; i < 3; i++)
        set_req(i, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      #1;
      for (int i = 0; i < 3; i++) exp_rdy[i] = !fl && (mq[i].size() < DEPTH);
      exp_busy = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < mq[i].size(); j++) begin
          h = mq[i][j];
          exp_busy[h.a] = 1'b1;
        end
      if (mw0) exp_busy[ma0] = 1'b1;
      if (mw1) exp_busy[ma1] = 1'b1;
      n_checks++; if (req_ready !== exp_rdy) $display("FAIL rand.ready cyc %0d got %b exp %b", c, req_ready, exp_rdy); else n_pass++;
      n_checks++; if (wen0 !== mw0) $display("FAIL rand.wen0 cyc %0d got %b exp %b", c, wen0, mw0); else n_pass++;
      if (mw0) begin
        n_checks++; if (waddr0 !== ma0 || wdata0 !== md0) $display("FAIL rand.port0 cyc %0d got %0d/%h exp %0d/%h", c, waddr0, wdata0, ma0, md0); else n_pass++;
      end
      n_checks++; if (wen1 !== mw1) $display("FAIL rand.wen1 cyc %0d got %b exp %b", c, wen1, mw1); else n_pass++;
      if (mw1) begin
        n_checks++; if (waddr1 !== ma1 || wdata1 !== md1) $display("FAIL rand.port1 cyc %0d got %0d/%h exp %0d/%h", c, waddr1, wdata1, ma1, md1); else n_pass++;
      end
      n_checks++; if (busy !== exp_busy) $display("FAIL rand.busy cyc %0d got %h exp %h", c, busy, exp_busy); else n_pass++;
      n_checks++; if (idle !== (mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && !mw0 && !mw1)) $display("FAIL rand.idle cyc %0d got %b", c, idle); else n_pass++;
      // model: oldest pending writes leave in rotation order, at most two, never two to one register
      nw0 = 1'b0; nw1 = 1'b0;
      if (fl) begin
        for (int i = 0; i < 3; i++) mq[i].delete();
      end else begin
        order.delete();
        for (int k = 0; k < 3; k++) begin
          r = (rr + k) % 3;
          if (mq[r].size() != 0) order.push_back(r);
        end
        if (order.size() >= 1) begin
          e = mq[order[0]].pop_front();
          nw0 = 1'b1; ma0 = e.a; md0 = e.d; last = order[0];
          if (order.size() >= 2) begin
            h = mq[order[1]][0];
            if (h.a != e.a) begin
              void'(mq[order[1]].pop_front());
              nw1 = 1'b1; ma1 = h.a; md1 = h.d; last = order[1];
            end
          end
          rr = (last + 1) % 3;
        end
        for (int i = 0; i < 3; i++)
          if (req_valid[i] && exp_rdy[i] && req_addr[i*AW +: AW] != '0) begin
            e.a = req_addr[i*AW +: AW];
            e.d = req_data[i*DW +: DW];
            mq[i].push_back(e);
          end
      end
      mw0 = nw0; mw1 = nw1;
      tick();
    end
    flush = 1'b0;
    clear_reqs();
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_rotation();
    test_conflict();
    test_backpressure();
    test_flush_r0();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
